// File: rtl/aes_axil_pkg.sv
// Shared constants for the AES AXI4-Lite register front end: register map,
// block width, response codes and the byte-strobe merge helper.
package aes_axil_pkg;

    localparam int REG_COUNT = 4;
    localparam int REG_W     = 32;
    localparam int BLK_W     = 128;

    localparam logic [3:0] ADDR_REG0 = 4'h0;
    localparam logic [3:0] ADDR_REG1 = 4'h4;
    localparam logic [3:0] ADDR_REG2 = 4'h8;
    localparam logic [3:0] ADDR_REG3 = 4'hC;

    // Writing the last word kicks off a block towards the core.
    localparam logic [1:0] LAUNCH_IDX = ADDR_REG3[3:2];

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [REG_W-1:0] strb_merge(
        input logic [REG_W-1:0]   old,
        input logic [REG_W-1:0]   data,
        input logic [REG_W/8-1:0] strb
    );
        logic [REG_W-1:0] r;
        r = old;
        for (int i = 0; i < REG_W / 8; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_blk_launcher.sv
// Snapshots the register file into a 128-bit block and hands it downstream
// over valid/ready, remembering at most one launch that arrives while busy.
module aes_blk_launcher
    import aes_axil_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic [BLK_W-1:0] regs,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid
);

    logic pending;
    logic free;

    // Output slot can take a new block when empty or being drained this cycle.
    assign free = ~blk_valid | blk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_valid <= 1'b0;
            blk_data  <= '0;
            pending   <= 1'b0;
        end else if (free) begin
            if (launch || pending) begin
                blk_valid <= 1'b1;
                blk_data  <= regs;
                pending   <= 1'b0;
            end else begin
                blk_valid <= 1'b0;
            end
        end else if (launch) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/aes_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit plaintext words; a write to the last
// word launches a block snapshot towards the AES core.
module aes_axil_regs
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [BLK_W-1:0]                blk_data,
    output logic                            blk_valid,
    input  logic                            blk_ready
);

    logic [REG_COUNT-1:0][REG_W-1:0] regs, regs_next;
    logic       wr_ready;
    logic       wr_hs, rd_hs, launch;
    logic [1:0] wr_idx;
    logic       unused;

    assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // One shared ready keeps AW and W acceptance locked together.
    assign AWREADY = wr_ready;
    assign WREADY  = wr_ready;
    assign BRESP   = RESP_OKAY;
    assign RRESP   = RESP_OKAY;

    assign wr_idx = AWADDR[3:2];
    assign wr_hs  = wr_ready & AWVALID & WVALID;
    assign rd_hs  = ARREADY & ARVALID;
    assign launch = wr_hs & (wr_idx == LAUNCH_IDX);

    always_comb begin
        regs_next = regs;
        if (wr_hs) regs_next[wr_idx] = strb_merge(regs[wr_idx], WDATA, WSTRB);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs     <= '0;
            wr_ready <= 1'b0;
            BVALID   <= 1'b0;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
        end else begin
            regs     <= regs_next;
            wr_ready <= ~wr_ready & AWVALID & WVALID & ~BVALID;
            if (wr_hs)       BVALID <= 1'b1;
            else if (BREADY) BVALID <= 1'b0;

            ARREADY <= ~ARREADY & ARVALID & ~RVALID;
            // Read samples registered state, so a same-cycle write is not visible.
            if (rd_hs) begin
                RVALID <= 1'b1;
                RDATA  <= regs[ARADDR[3:2]];
            end else if (RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    // Launcher sees post-write contents so the snapshot includes the launching write.
    aes_blk_launcher u_launch (
        .clk       (ACLK),
        .rst       (ARESET),
        .launch    (launch),
        .regs      (regs_next),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid)
    );

endmodule

// File: tb/tb_aes_axil_regs.sv
// Bench for aes_axil_regs: directed corner cases plus random register traffic
// checked against an array model of the register file.
module tb_aes_axil_regs;

    logic         ACLK, ARESET;
    logic [3:0]   AWADDR, ARADDR;
    logic [2:0]   AWPROT, ARPROT;
    logic         AWVALID, AWREADY, WVALID, WREADY;
    logic [31:0]  WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic         BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [127:0] blk_data;
    logic         blk_valid, blk_ready;

    int          n_chk = 0, n_err = 0;
    logic [31:0] m [4];
    logic [31:0] rd;

    aes_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [127:0] model_blk();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic wait_aw;
        int n = 0;
        while (!AWREADY && n < 20) begin tick(); n++; end
        chk("aw_ready", AWREADY, 1'b1);
        chk("w_with_aw", WREADY, AWREADY);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        wait_aw();
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        m[a[3:2]] = merge(m[a[3:2]], d, s);
        chk("bvalid", BVALID, 1'b1);
        chk("bresp", BRESP, 2'b00);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        chk("ar_ready", ARREADY, 1'b1);
        tick();
        ARVALID = 1'b0;
        chk("rvalid", RVALID, 1'b1);
        chk("rresp", RRESP, 2'b00);
        d = RDATA;
    endtask

    initial begin
        int n;
        ARESET = 1'b1; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; WDATA = '0; WSTRB = '0; ARVALID = 0;
        BREADY = 1; RREADY = 1; blk_ready = 0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        repeat (3) tick();
        chk("rst_awready", AWREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, 128'h0);
        ARESET = 1'b0;
        tick();

        // Basic map and launch
        blk_ready = 1;
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        chk("launch_valid", blk_valid, 1'b1);
        chk("launch_data", blk_data, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            chk("map_read", rd, 32'(i + 1));
        end

        // Byte strobes
        axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
        axi_read(4'h4, rd);
        chk("strb_read", rd, 32'h0000CC02);

        // Same-cycle read and write of one register
        tick(); tick();
        ARADDR = 4'h4; ARVALID = 1; AWADDR = 4'h4; WDATA = 32'h55; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1;
        wait_aw();
        chk("ar_with_aw", ARREADY, 1'b1);
        tick();
        ARVALID = 0; AWVALID = 0; WVALID = 0;
        chk("rw_old_value", RDATA, 32'h0000CC02);
        m[1] = 32'h55;
        axi_read(4'h4, rd);
        chk("rw_new_value", rd, 32'h55);

        // Back-pressured block with merged pending launch
        blk_ready = 0;
        tick();
        chk("bp_idle", blk_valid, 1'b0);
        axi_write(4'hC, 32'h10, 4'hF);
        chk("bp_first", blk_data, model_blk());
        axi_write(4'hC, 32'h20, 4'hF);
        repeat (2) tick();
        chk("bp_held_valid", blk_valid, 1'b1);
        chk("bp_held_data", blk_data[127:96], 32'h10);
        blk_ready = 1;
        n = 0;
        tick();
        while (!(blk_valid && blk_data[127:96] == 32'h20) && n < 3) begin tick(); n++; end
        chk("bp_second_valid", blk_valid, 1'b1);
        chk("bp_second_data", blk_data, model_blk());
        tick();
        chk("bp_drained", blk_valid, 1'b0);

        // Launch coinciding with acceptance
        blk_ready = 0;
        axi_write(4'hC, 32'hA1, 4'hF);
        chk("co_first", blk_data[127:96], 32'hA1);
        AWADDR = 4'hC; WDATA = 32'hB2; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        wait_aw();
        blk_ready = 1;
        tick();
        AWVALID = 0; WVALID = 0;
        m[3] = 32'hB2;
        n = 0;
        while (!(blk_valid && blk_data[127:96] == 32'hB2) && n < 3) begin tick(); n++; end
        chk("co_second", blk_data, model_blk());
        tick();
        chk("co_drained", blk_valid, 1'b0);

        // Write response back-pressure blocks a queued write
        BREADY = 0;
        axi_write(4'h0, 32'h77, 4'hF);
        AWADDR = 4'h8; WDATA = 32'h88; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bstall_bvalid", BVALID, 1'b1);
            chk("bstall_awready", AWREADY, 1'b0);
            chk("bstall_wready", WREADY, 1'b0);
        end
        BREADY = 1;
        wait_aw();
        tick();
        AWVALID = 0; WVALID = 0;
        m[2] = 32'h88;
        chk("bstall_second_b", BVALID, 1'b1);
        axi_read(4'h0, rd);
        chk("bstall_r0", rd, 32'h77);
        axi_read(4'h8, rd);
        chk("bstall_r8", rd, 32'h88);

        // Reset in the middle of a read response and a pending block
        blk_ready = 0;
        tick(); tick();
        axi_write(4'hC, 32'h99, 4'hF);
        RREADY = 0;
        axi_read(4'h8, rd);
        tick();
        chk("pre_rst_rvalid", RVALID, 1'b1);
        chk("pre_rst_blk", blk_valid, 1'b1);
        #2 ARESET = 1;
        #1;
        chk("mid_rst_rvalid", RVALID, 1'b0);
        chk("mid_rst_blk", blk_valid, 1'b0);
        chk("mid_rst_blk_data", blk_data, 128'h0);
        for (int i = 0; i < 4; i++) m[i] = '0;
        #3 ARESET = 0;
        RREADY = 1;
        tick();
        chk("post_rst_rvalid", RVALID, 1'b0);
        chk("post_rst_bvalid", BVALID, 1'b0);
        axi_read(4'h8, rd);
        chk("post_rst_r8", rd, 32'h0);

        // Random traffic
        blk_ready = 1;
        for (int it = 0; it < 200; it++) begin
            logic [1:0] idx;
            logic [3:0] a, s;
            logic [31:0] d;
            idx = 2'($urandom_range(0, 3));
            a = {idx, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s);
                if (idx == 2'd3) begin
                    chk("rnd_launch_valid", blk_valid, 1'b1);
                    chk("rnd_launch_data", blk_data, model_blk());
                end
            end else begin
                axi_read(a, rd);
                chk("rnd_read", rd, m[idx]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/aes_axil_regs.md
AES_AXIL_REGS -- requirements
Module: aes_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 word registers).
REQ-003 SHALL have port ACLK  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port ARESET  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports AWADDR in 4, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1  write address channel.
REQ-006 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1  write data channel.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1  write response channel.
REQ-008 SHALL have ports ARADDR in 4, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1  read address channel.
REQ-009 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1  read data channel.
REQ-010 SHALL have ports blk_data out 128, blk_valid out 1, blk_ready in 1  plaintext block to downstream AES core.

Function
REQ-011 SHALL hold four 32-bit registers REG0..REG3 at byte offsets 0x0/0x4/0x8/0xC, selected by address bits [3:2]; bits [1:0] ignored.
REQ-012 SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID=1, WVALID=1 and BVALID=0; never one without the other.
REQ-013 SHALL update the addressed register in the handshake cycle, byte lane n written only when WSTRB[n]=1.
REQ-014 SHALL assert BVALID the cycle after the write handshake, BRESP=2'b00, held until BREADY=1 sampled.
REQ-015 SHALL assert ARREADY for one cycle when ARVALID=1 and RVALID=0; RVALID asserted next cycle with RDATA = addressed register, RRESP=2'b00, both stable until RREADY=1 sampled.
REQ-016 SHALL accept a read and a write in the same cycle independently; a read of a register written that cycle returns the pre-write value.
REQ-017 SHALL treat a completed write to 0xC as a launch request (any WSTRB, including 0).
REQ-018 SHALL, on launch while blk_valid=0, assert blk_valid the next cycle with blk_data = {REG3,REG2,REG1,REG0} snapshot taken after the write.
REQ-019 SHALL hold blk_valid and blk_data stable until blk_ready=1 sampled; blk_valid deasserts the following cycle unless a launch is pending.
REQ-020 SHALL keep one pending-launch flag: a launch while blk_valid=1 sets it; further launches while set are merged (flag stays 1, no counter).
REQ-021 SHALL, when the current block is accepted and pending=1, clear pending and present a fresh snapshot with blk_valid=1 in the next cycle (one-cycle bubble allowed).
REQ-022 SHALL, when launch and blk_ready acceptance coincide in one cycle, treat the launch as pending (REQ-021 path).
REQ-023 SHALL never stall AXI writes because of blk_ready; register updates after snapshot do not alter a presented blk_data.

Reset
REQ-024 SHALL on ARESET=1 immediately clear REG0..REG3, pending flag, blk_data to 0, and drive AWREADY, WREADY, BVALID, ARREADY, RVALID, blk_valid to 0, BRESP/RRESP/RDATA to 0.
REQ-025 SHALL abandon any in-flight AXI response or block transfer on reset mid-operation; no response issued after reset release.
REQ-026 SHALL accept the first handshake no earlier than the first rising edge after ARESET deasserts.

Structure
REQ-027 SHALL place address offsets (0x0/0x4/0x8/0xC), register count, block width 128 and RESP_OKAY in shared package aes_axil_pkg.
REQ-028 SHALL implement the snapshot/valid-ready/pending logic as sub-module aes_blk_launcher (inputs launch, regs[127:0], blk_ready; outputs blk_data, blk_valid).

Verification
REQ-029 SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0..0xC, BREADY=1 -> reads return 0x1..0x4, BRESP=RRESP=0; blk_data=0x00000004_00000003_00000002_00000001 one cycle after 0xC write.
REQ-030 SHALL cover: WSTRB=4'b0010, WDATA=0xAABBCCDD to 0x4 (prior 0x2) -> read 0x4 returns 0x0000CC02.
REQ-031 SHALL cover: blk_ready=0, write 0xC twice (0x10, then 0x20) -> blk_data[127:96]=0x10 held; after blk_ready=1 one cycle, next block shows 0x20, then blk_valid=0.
REQ-032 SHALL cover: BREADY=0 for 5 cycles after write -> BVALID held, AWREADY/WREADY stay 0 for a second queued write until B accepted.
REQ-033 SHALL cover: ARESET pulse while RVALID=1 and blk_valid=1 -> both 0 immediately; read of 0x8 after release returns 0x0.
